// File: rtl/sb_bus_pkg.sv
// Shared system-bus definitions: responder FSM states, word-count width
// and the burst-length helper.
package sb_bus_pkg;

    localparam int unsigned WORD_CNT_W = 9;
    localparam int unsigned BURST_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        RD_END,
        WR_DATA,
        WR_BUSY,
        ERR
    } sb_state_e;

    // Number of words in a burst; 255 maps to 256, hence the 9-bit result.
    function automatic logic [WORD_CNT_W-1:0] burst_words(input logic [BURST_W-1:0] burst_size);
        return WORD_CNT_W'(burst_size) + WORD_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sb_mem_responder_if.sv
// System-bus signal bundle between a master and the memory responder.
// Inputs (_i) are driven by the master, outputs (_o) by the responder;
// responder outputs are 0 when idle so several slaves can be OR-combined.
interface sb_mem_responder_if;

    logic        sb_begin_transaction_i;
    logic        sb_end_transaction_i;
    logic        sb_data_valid_i;
    logic [31:0] sb_address_data_i;
    logic [3:0]  sb_byte_enables_i;
    logic [7:0]  sb_burst_size_i;
    logic        sb_read_n_write_i;

    logic [31:0] sb_address_data_o;
    logic        sb_data_valid_o;
    logic        sb_end_transaction_o;
    logic        sb_busy_o;
    logic        sb_error_o;

    modport slave (
        input  sb_begin_transaction_i, sb_end_transaction_i, sb_data_valid_i,
               sb_address_data_i, sb_byte_enables_i, sb_burst_size_i, sb_read_n_write_i,
        output sb_address_data_o, sb_data_valid_o, sb_end_transaction_o, sb_busy_o, sb_error_o
    );

    modport master (
        output sb_begin_transaction_i, sb_end_transaction_i, sb_data_valid_i,
               sb_address_data_i, sb_byte_enables_i, sb_burst_size_i, sb_read_n_write_i,
        input  sb_address_data_o, sb_data_valid_o, sb_end_transaction_o, sb_busy_o, sb_error_o
    );

endinterface

// File: rtl/sb_word_ram.sv
// Synchronous single-port WORDS x 32 RAM with byte write enables.
// Ports: clk, rst_n (clears only the read register), rd_en, wr_en, addr,
// be (bit0 = [7:0]), wdata, rdata (registered; 0 on cycles without a read).
module sb_word_ram #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // Byte-lane write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register doubles as the bus data driver, so it returns to 0 when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/sb_mem_responder.sv
// System-bus memory responder: claims accesses inside a word window and
// serves read/write bursts from an internal RAM.
// Ports: sb_clock_i, sb_reset_n_i (synchronous, active low), bus (slave
// modport: begin/end/data_valid/address_data/byte_enables/burst_size/
// read_n_write in; address_data/data_valid/end/busy/error out).
module sb_mem_responder
    import sb_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned SIZE_WORDS   = 1024,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned WRITE_WAIT   = 0
) (
    input  logic              sb_clock_i,
    input  logic              sb_reset_n_i,
    sb_mem_responder_if.slave bus
);

    localparam int unsigned AW          = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;
    localparam logic [32:0] WIN_LO      = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI      = WIN_LO + (33'(SIZE_WORDS) << 2);
    localparam logic [3:0]  RD_WAIT_INI = 4'(READ_LATENCY - 2);
    localparam logic [3:0]  WR_WAIT_INI = 4'(WRITE_WAIT - 1);

    sb_state_e             state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [WORD_CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]            wait_q, wait_d;
    logic                  dv_q, dv_d;
    logic                  end_q, end_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    logic                  in_window;
    logic                  burst_fits;
    logic [29:0]           req_idx;
    logic [30:0]           req_last;
    logic                  issue;
    logic                  ram_rd;
    logic                  ram_wr;
    logic [AW-1:0]         ram_addr;
    logic [31:0]           ram_rdata;

    // Address decode for the begin cycle.
    assign in_window  = ({1'b0, bus.sb_address_data_i} >= WIN_LO) &&
                        ({1'b0, bus.sb_address_data_i} <  WIN_HI);
    assign req_idx    = bus.sb_address_data_i[31:2] - BASE_ADDR[31:2];
    assign req_last   = 31'(req_idx) + 31'(bus.sb_burst_size_i);
    assign burst_fits = req_last < 31'(SIZE_WORDS);

    // State and registered outputs.
    always_ff @(posedge sb_clock_i) begin
        if (!sb_reset_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            dv_q    <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            dv_q    <= dv_d;
            end_q   <= end_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next state, counters and next output values.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        dv_d     = 1'b0;
        end_d    = 1'b0;
        err_d    = 1'b0;
        busy_d   = 1'b0;
        ram_rd   = 1'b0;
        ram_wr   = 1'b0;
        ram_addr = addr_q;
        issue    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.sb_begin_transaction_i && in_window) begin
                    addr_d = req_idx[AW-1:0];
                    cnt_d  = burst_words(bus.sb_burst_size_i);
                    if (!burst_fits) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else if (!bus.sb_read_n_write_i) begin
                        state_d = WR_DATA;
                    end else if (READ_LATENCY <= 1) begin
                        // The RAM read cycle alone covers a latency of one.
                        ram_addr = req_idx[AW-1:0];
                        issue    = 1'b1;
                    end else begin
                        wait_d  = RD_WAIT_INI;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (bus.sb_end_transaction_i) begin
                    state_d = IDLE;
                end else if (wait_q == '0) begin
                    issue = 1'b1;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            RD_DATA: begin
                if (bus.sb_end_transaction_i) begin
                    state_d = IDLE;
                end else begin
                    issue = 1'b1;
                end
            end
            RD_END: begin
                end_d   = 1'b1;
                state_d = IDLE;
            end
            WR_DATA: begin
                // cnt_q == 0 means the burst is full; extra words are dropped.
                if (bus.sb_data_valid_i && (cnt_q != '0)) begin
                    ram_wr = 1'b1;
                    addr_d = addr_q + AW'(1);
                    cnt_d  = cnt_q - WORD_CNT_W'(1);
                    if (WRITE_WAIT != 0) begin
                        busy_d  = 1'b1;
                        wait_d  = WR_WAIT_INI;
                        state_d = WR_BUSY;
                    end
                end
                if (bus.sb_end_transaction_i) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            WR_BUSY: begin
                if (bus.sb_end_transaction_i) begin
                    state_d = IDLE;
                end else if (wait_q == '0) begin
                    state_d = WR_DATA;
                end else begin
                    busy_d = 1'b1;
                    wait_d = wait_q - 4'd1;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Launch one read word; data_valid lines up with the RAM output register.
        if (issue) begin
            ram_rd  = 1'b1;
            dv_d    = 1'b1;
            addr_d  = ram_addr + AW'(1);
            state_d = (cnt_d == WORD_CNT_W'(1)) ? RD_END : RD_DATA;
            cnt_d   = cnt_d - WORD_CNT_W'(1);
        end
    end

    sb_word_ram #(
        .WORDS (SIZE_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (sb_clock_i),
        .rst_n (sb_reset_n_i),
        .rd_en (ram_rd),
        .wr_en (ram_wr & sb_reset_n_i),
        .addr  (ram_addr),
        .be    (bus.sb_byte_enables_i),
        .wdata (bus.sb_address_data_i),
        .rdata (ram_rdata)
    );

    assign bus.sb_address_data_o    = ram_rdata;
    assign bus.sb_data_valid_o      = dv_q;
    assign bus.sb_end_transaction_o = end_q;
    assign bus.sb_busy_o            = busy_q;
    assign bus.sb_error_o           = err_q;

endmodule
